// File: rtl/alu_cmd_responder.sv
// alu_cmd_responder
//   Responder end of the 12-bit ALU instruction interface.
//   Instruction word: {opcode[11:8], in1[7:4], in2[3:0]}.
//   Response word:    {opcode[3:0], carry, zero, err, 1'b0, result[3:0]}.
//   Accepted words go through one registered execute stage. They then wait in a
//   DEPTH-entry circular FIFO until the result sink takes them.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
//   valid && ready are both high. A source holds valid and data stable until
//   that edge. cmd_ready depends on registered state only. rsp_data is stable
//   while rsp_valid && !rsp_ready.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready/data instruction channel (12-bit words)
//   rsp_valid/ready/data response channel (12-bit tagged results)
//   busy                 execute stage valid or FIFO non-empty
//   op_count, err_count  legal / illegal words executed (only when the
//                        ALU_STATS_EN macro is defined; saturating)
//
// Optional feature macro: ALU_STATS_EN.
module alu_cmd_responder #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [11:0] rsp_data,
  output logic        busy
`ifdef ALU_STATS_EN
  ,
  output logic [15:0] op_count,
  output logic [7:0]  err_count
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Registered state
  logic          en_q,       en_d;        // low until the first clk after reset
  logic          ex_vld_q,   ex_vld_d;
  logic [11:0]   ex_word_q,  ex_word_d;
  logic          ex_xz_q,    ex_xz_d;     // accepted word contained X/Z
  logic [11:0]   mem_q [DEPTH];
  logic [11:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW:0]   count_q,    count_d;
  logic [11:0]   last_q,     last_d;      // last popped word, shown while empty

  // Execute-stage decode
  logic [3:0]  op, a, b, res;
  logic [1:0]  sh;
  logic [4:0]  sum5;
  logic [7:0]  shl_t, shr_t;
  logic        carry, zero, err;
  logic [11:0] ex_rsp;

  logic        accept, push, pop;
  logic [AW:0] occ;

  // Words in flight (execute stage + FIFO) never exceed DEPTH. A word in the
  // execute stage therefore always finds a free FIFO slot on the next edge.
  assign occ       = count_q + {{AW{1'b0}}, ex_vld_q};
  assign cmd_ready = en_q && (occ < DEPTH_C);
  assign rsp_valid = (count_q != '0);
  assign rsp_data  = rsp_valid ? mem_q[rd_ptr_q] : last_q;
  assign busy      = ex_vld_q | (count_q != '0);

  assign accept = cmd_valid && cmd_ready;
  assign push   = ex_vld_q;
  assign pop    = rsp_valid && rsp_ready;

  always_comb begin
    op    = ex_word_q[11:8];
    a     = ex_word_q[7:4];
    b     = ex_word_q[3:0];
    sh    = b[1:0];
    sum5  = {1'b0, a} + {1'b0, b};
    // Shift in a widened window: the bit just past the 4-bit result is the
    // last bit shifted out. That bit is zero when the shift amount is zero.
    shl_t = {4'b0000, a} << sh;
    shr_t = {a, 4'b0000} >> sh;
    res   = 4'h0;
    carry = 1'b0;
    err   = 1'b0;
    case (op)
      4'd0: begin res = sum5[3:0];    carry = sum5[4];  end
      4'd1: begin res = a - b;        carry = (a < b);  end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ~a;
      4'd6: begin res = shl_t[3:0];   carry = shl_t[4]; end
      4'd7: begin res = shr_t[7:4];   carry = shr_t[3]; end
      4'd8: res = a;
      4'd9: res = b;
      default: err = 1'b1;
    endcase
    if (ex_xz_q) begin
      res   = 4'h0;
      carry = 1'b0;
      err   = 1'b1;
    end
    zero   = (res == 4'h0);
    ex_rsp = {op, carry, zero, err, 1'b0, res};
  end

  always_comb begin
    en_d      = 1'b1;
    ex_vld_d  = accept;
    ex_word_d = accept ? cmd_data : ex_word_q;
    ex_xz_d   = accept ? $isunknown(cmd_data) : ex_xz_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    last_d    = last_q;
    if (push) begin
      mem_d[wr_ptr_q] = ex_rsp;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      ex_vld_q  <= 1'b0;
      ex_word_q <= '0;
      ex_xz_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_q    <= '0;
    end else begin
      en_q      <= en_d;
      ex_vld_q  <= ex_vld_d;
      ex_word_q <= ex_word_d;
      ex_xz_q   <= ex_xz_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
    end
  end

`ifdef ALU_STATS_EN
  logic [15:0] op_cnt_q,  op_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Counted when the word enters the FIFO; both saturate at all-ones.
  always_comb begin
    op_cnt_d  = op_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      if (err) begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        if (op_cnt_q != 16'hFFFF) op_cnt_d = op_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      op_cnt_q  <= op_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign op_count  = op_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Testbench for alu_cmd_responder: table of hand-derived vectors, FIFO
// back-pressure / ordering sequence, randomized traffic against a reference
// model + expected queue, and an asynchronous reset with responses pending.
module tb_alu_cmd_responder;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [11:0] rsp_data;
  logic        busy;
`ifdef ALU_STATS_EN
  logic [15:0] op_count;
  logic [7:0]  err_count;
`endif

  always #5 clk = ~clk;

  alu_cmd_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef ALU_STATS_EN
    ,
    .op_count  (op_count),
    .err_count (err_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_q[$];
  int          acc_n = 0;      // words accepted since reset
  int          pop_n = 0;      // responses taken since reset
  int          legal_n = 0;
  int          illegal_n = 0;
  logic        hold_pending = 1'b0;
  logic [11:0] hold_data = '0;
  logic        empty_pending = 1'b0;
  logic [11:0] last_pop = '0;
  logic        last_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: response word computed from the opcode table with plain
  // integer arithmetic.
  function automatic logic [11:0] ref_rsp(input logic [11:0] w);
    int op, a, b, sh, r, c, e;
    op = int'(w[11:8]); a = int'(w[7:4]); b = int'(w[3:0]);
    sh = b % 4; r = 0; c = 0; e = 0;
    case (op)
      0: begin r = a + b; c = r / 16; r = r % 16; end
      1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin r = a * (1 << sh); c = (sh != 0) ? (r / 16) % 2 : 0; r = r % 16; end
      7: begin r = a / (1 << sh); c = (sh != 0) ? (a / (1 << (sh - 1))) % 2 : 0; end
      8: r = a;
      9: r = b;
      default: e = 1;
    endcase
    return {w[11:8], c[0], (r == 0), e[0], 1'b0, r[3:0]};
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive at negedge, sample 1 ns later, update the model
  // for the handshakes that complete on the following posedge.
  task automatic cycle(input logic v, input logic [11:0] w, input logic rr,
                       output logic acc, output logic vld, output logic [11:0] dat);
    logic [11:0] e;
    @(negedge clk);
    cmd_valid = v; cmd_data = w; rsp_ready = rr;
    #1;
    vld = rsp_valid; dat = rsp_data; last_ready = cmd_ready;
    chk("cmd_ready", cmd_ready, ((acc_n - pop_n) < DEPTH) ? 1 : 0);
    chk("busy", busy, (acc_n != pop_n) ? 1 : 0);
    if (hold_pending) begin
      chk("hold_valid", vld, 1);
      chk("hold_data", dat, hold_data);
    end
    if (empty_pending && !vld) chk("empty_hold_data", dat, last_pop);
    if (exp_q.size() == 0) chk("rsp_unexpected", vld, 0);
    acc = v && cmd_ready;
    if (acc) begin
      e = ref_rsp(w);
      exp_q.push_back(e);
      acc_n++;
      if (e[5]) illegal_n++; else legal_n++;
    end
    empty_pending = 1'b0;
    if (vld && rr && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rsp_order_data", dat, e);
      pop_n++;
      last_pop = dat;
      empty_pending = 1'b1;
    end
    hold_pending = vld && !rr;
    hold_data    = dat;
    @(posedge clk);
  endtask

  task automatic clear_model();
    exp_q.delete();
    acc_n = 0; pop_n = 0; legal_n = 0; illegal_n = 0;
    hold_pending = 1'b0; empty_pending = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_clk", cmd_ready, 0);
    @(posedge clk);
    clear_model();
  endtask

  task automatic drain();
    logic a, v; logic [11:0] d;
    for (int i = 0; i < 40 && acc_n != pop_n; i++) cycle(1'b0, 12'h000, 1'b1, a, v, d);
    chk("drain_outstanding", acc_n - pop_n, 0);
    cycle(1'b0, 12'h000, 1'b1, a, v, d);
    cycle(1'b0, 12'h000, 1'b1, a, v, d);
  endtask

  task automatic chk_stats();
`ifdef ALU_STATS_EN
    chk("op_count", 32'(op_count), legal_n);
    chk("err_count", 32'(err_count), illegal_n);
`endif
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [11:0] cmd;
    logic [11:0] rsp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic a, v;
    logic [11:0] d;
    int sent;
    logic [11:0] words[6];

    tbl[0]  = '{12'h123, 12'h18F};  // SUB 2-3 -> F, borrow
    tbl[1]  = '{12'h0F1, 12'h0C0};  // ADD 15+1 -> 0, carry, zero
    tbl[2]  = '{12'h034, 12'h007};  // ADD 3+4
    tbl[3]  = '{12'hA55, 12'hA60};  // illegal: zero + err
    tbl[4]  = '{12'h692, 12'h604};  // SHL 9<<2
    tbl[5]  = '{12'h7B1, 12'h785};  // SHR 11>>1, carry
    tbl[6]  = '{12'h2C6, 12'h204};  // AND
    tbl[7]  = '{12'h3C3, 12'h30F};  // OR
    tbl[8]  = '{12'h455, 12'h440};  // XOR -> zero
    tbl[9]  = '{12'h5F0, 12'h540};  // NOT 15 -> zero
    tbl[10] = '{12'h8A0, 12'h80A};  // PASS in1
    tbl[11] = '{12'h90B, 12'h90B};  // PASS in2
    tbl[12] = '{12'h700, 12'h740};  // SHR by 0, carry 0
    tbl[13] = '{12'h6F3, 12'h688};  // SHL 15<<3, carry = in1[1]
    tbl[14] = '{12'hF00, 12'hF60};  // illegal top opcode

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    release_reset();
    chk_stats();

    // Table: accept, check 2-cycle latency and the response word.
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, tbl[i].cmd, 1'b1, a, v, d);
      chk("tbl_accept", a, 1);
      cycle(1'b0, 12'h000, 1'b1, a, v, d);
      chk("tbl_latency_1", v, 0);
      cycle(1'b0, 12'h000, 1'b1, a, v, d);
      chk("tbl_latency_2", v, 1);
      chk("tbl_rsp_data", d, tbl[i].rsp);
    end
    drain();
    chk_stats();

    // Back-pressure: 6 words against a stalled sink, only DEPTH fit.
    for (int i = 0; i < 6; i++) words[i] = 12'($urandom_range(0, 4095));
    sent = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(sent < 6, (sent < 6) ? words[sent] : 12'h000, 1'b0, a, v, d);
      if (a) sent++;
    end
    chk("full_accepted", sent, DEPTH);
    chk("full_cmd_ready", last_ready, 0);
    for (int i = 0; i < 40 && (sent < 6 || acc_n != pop_n); i++) begin
      cycle(sent < 6, (sent < 6) ? words[sent] : 12'h000, 1'b1, a, v, d);
      if (a) sent++;
    end
    chk("full_remaining_accepted", sent, 6);
    drain();

    // Back-to-back throughput with an always-ready sink.
    sent = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b1, a, v, d);
      if (a) sent++;
    end
    chk("b2b_accepts", sent, 8);
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
            ($urandom_range(0, 3) != 0), a, v, d);
    drain();
    chk_stats();

    // Asynchronous reset with 3 responses pending.
    for (int i = 0; i < 3; i++) cycle(1'b1, 12'h123 + 12'(i), 1'b0, a, v, d);
    cycle(1'b0, 12'h000, 1'b0, a, v, d);
    chk("pending_before_reset", acc_n - pop_n, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    release_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 12'h000, 1'b1, a, v, d);
      chk("post_rst_no_stale", v, 0);
    end
    chk("post_rst_ready", last_ready, 1);
    chk_stats();
    cycle(1'b1, 12'h034, 1'b1, a, v, d);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
